// File: rtl/mii_frame_monitor.sv
// Checks framing of a multi-lane MII-style character stream: frame length, inter-packet gap
// and control-character placement, with saturating frame and error statistics.
module mii_frame_monitor #(
  parameter int unsigned NUM_LANES        = 8,
  parameter logic [7:0]  IDLE_CODE        = 8'h07,
  parameter logic [7:0]  START_CODE       = 8'hFB,
  parameter logic [7:0]  TERM_CODE        = 8'hFD,
  parameter int unsigned MIN_LEN          = 46,
  parameter int unsigned MAX_LEN          = 1500,
  parameter int unsigned MIN_IPG          = 12,
  parameter int unsigned MAX_IPG          = 40,
  parameter int unsigned CNT_W            = 16,
  parameter bit          START_LANE0_ONLY = 1'b1
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [8*NUM_LANES-1:0] i_data,
  input  logic [NUM_LANES-1:0]   i_ctrl,
  input  logic                   i_clear,
  output logic                   o_frame_done,
  output logic [CNT_W-1:0]       o_frame_len,
  output logic                   o_len_error,
  output logic                   o_ipg_error,
  output logic                   o_ctrl_error,
  output logic [CNT_W-1:0]       o_frame_count,
  output logic [CNT_W-1:0]       o_error_count,
  output logic                   o_busy
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MinLen = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MinIpg = CNT_W'(MIN_IPG);
  localparam logic [CNT_W-1:0] MaxIpg = CNT_W'(MAX_IPG);
  localparam logic [4:0]       Lanes  = 5'(NUM_LANES);

  typedef enum logic [1:0] {StWaitFirst, StInFrame, StInGap} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q, gap_q;

  logic       start_hit, idle_err, term_hit, frame_abort, tail_err;
  logic [4:0] start_lane, term_lane;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? CntMax : sum[CNT_W-1:0];
  endfunction

  // Lane scan. Lanes after a valid START are frame bytes and are not checked here.
  always_comb begin
    start_hit   = 1'b0;
    start_lane  = '0;
    idle_err    = 1'b0;
    term_hit    = 1'b0;
    term_lane   = '0;
    frame_abort = 1'b0;
    tail_err    = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!start_hit) begin
        if (i_ctrl[k] && i_data[8*k +: 8] == START_CODE && (k == 0 || !START_LANE0_ONLY)) begin
          start_hit  = 1'b1;
          start_lane = 5'(k);
        end else if (!i_ctrl[k] || i_data[8*k +: 8] != IDLE_CODE) begin
          idle_err = 1'b1;
        end
      end
      if (!term_hit) begin
        if (i_ctrl[k] && i_data[8*k +: 8] == TERM_CODE) begin
          term_hit  = 1'b1;
          term_lane = 5'(k);
        end else if (i_ctrl[k]) begin
          frame_abort = 1'b1;
        end
      end else if (!i_ctrl[k] || i_data[8*k +: 8] != IDLE_CODE) begin
        tail_err = 1'b1;
      end
    end
  end

  logic [CNT_W-1:0] len_term, len_step, gap_start, gap_step, len_load, gap_load;
  logic             len_bad, ipg_bad;

  assign len_term  = sat_add(len_q, term_lane);
  assign len_step  = sat_add(len_q, Lanes);
  assign gap_start = sat_add(gap_q, start_lane);
  assign gap_step  = sat_add(gap_q, Lanes);
  assign len_load  = CNT_W'(Lanes - 5'd1 - start_lane);
  assign gap_load  = CNT_W'(Lanes - term_lane);
  // A saturated length is treated as oversize even if MAX_LEN is unreachable.
  assign len_bad   = (len_term < MinLen) || (len_term > MaxLen) || (len_term == CntMax);
  assign ipg_bad   = (gap_start < MinIpg) || (gap_start > MaxIpg);

  assign o_busy = (state_q == StInFrame);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StWaitFirst;
      len_q         <= '0;
      gap_q         <= '0;
      o_frame_done  <= 1'b0;
      o_frame_len   <= '0;
      o_len_error   <= 1'b0;
      o_ipg_error   <= 1'b0;
      o_ctrl_error  <= 1'b0;
      o_frame_count <= '0;
      o_error_count <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_len_error  <= 1'b0;
      o_ipg_error  <= 1'b0;
      o_ctrl_error <= 1'b0;

      // Statistics follow the pulses currently on the outputs; clear takes priority.
      if (i_clear) begin
        o_frame_count <= '0;
        o_error_count <= '0;
      end else begin
        if (o_frame_done && o_frame_count != CntMax) o_frame_count <= o_frame_count + CNT_W'(1);
        if ((o_len_error || o_ipg_error || o_ctrl_error) && o_error_count != CntMax) begin
          o_error_count <= o_error_count + CNT_W'(1);
        end
      end

      if (i_valid) begin
        case (state_q)
          StWaitFirst, StInGap: begin
            o_ctrl_error <= idle_err;
            if (start_hit) begin
              state_q <= StInFrame;
              len_q   <= len_load;
              if (state_q == StInGap) begin
                gap_q       <= gap_start;
                o_ipg_error <= ipg_bad;
              end
            end else if (state_q == StInGap) begin
              gap_q <= gap_step;
            end
          end
          StInFrame: begin
            if (frame_abort) begin
              o_ctrl_error <= 1'b1;
              state_q      <= StWaitFirst;
            end else if (term_hit) begin
              len_q        <= len_term;
              o_frame_len  <= len_term;
              o_frame_done <= 1'b1;
              o_len_error  <= len_bad;
              o_ctrl_error <= tail_err;
              gap_q        <= gap_load;
              state_q      <= StInGap;
            end else begin
              len_q <= len_step;
            end
          end
          default: state_q <= StWaitFirst;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Self-checking bench for mii_frame_monitor: directed framing scenarios plus randomized
// traffic compared against a byte-by-byte stream model.
module tb_mii_frame_monitor;

  localparam int NL   = 8;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n, valid, clear;
  logic [63:0] data;
  logic [7:0]  ctrl;
  logic        done, len_err, ipg_err, ctrl_err, busy;
  logic [15:0] flen, fcnt, ecnt;

  always #5 clk = ~clk;

  mii_frame_monitor dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_data        (data),
    .i_ctrl        (ctrl),
    .i_clear       (clear),
    .o_frame_done  (done),
    .o_frame_len   (flen),
    .o_len_error   (len_err),
    .o_ipg_error   (ipg_err),
    .o_ctrl_error  (ctrl_err),
    .o_frame_count (fcnt),
    .o_error_count (ecnt),
    .o_busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {MWait, MFrame, MGap} mmode_e;
  typedef struct {
    bit          v;
    logic [63:0] d;
    logic [7:0]  c;
  } beat_t;

  mmode_e m_mode;
  int     m_len, m_gap, m_flen, m_fc, m_ec;
  bit     m_done, m_len_err, m_ipg_err, m_ctrl_err;

  task automatic model_reset();
    m_mode = MWait;
    m_len = 0; m_gap = 0; m_flen = 0; m_fc = 0; m_ec = 0;
    m_done = 0; m_len_err = 0; m_ipg_err = 0; m_ctrl_err = 0;
  endtask

  // Walks the beat one character at a time; lengths and gaps are plain byte tallies.
  task automatic model_beat(input beat_t b, input bit clr);
    bit started, ended, isc;
    byte unsigned ch;
    started = 0;
    ended   = 0;
    if (clr) begin
      m_fc = 0;
      m_ec = 0;
    end else begin
      if (m_done && m_fc < CMAX) m_fc++;
      if ((m_len_err || m_ipg_err || m_ctrl_err) && m_ec < CMAX) m_ec++;
    end
    m_done = 0; m_len_err = 0; m_ipg_err = 0; m_ctrl_err = 0;
    if (!b.v) return;
    for (int k = 0; k < NL; k++) begin
      ch  = b.d[8*k +: 8];
      isc = b.c[k];
      if (started) begin
        m_len++;
      end else if (ended) begin
        if (!isc || ch != 8'h07) m_ctrl_err = 1;
        m_gap++;
      end else if (m_mode == MFrame) begin
        if (isc && ch == 8'hFD) begin
          m_flen    = (m_len > CMAX) ? CMAX : m_len;
          m_done    = 1;
          m_len_err = (m_flen < 46) || (m_flen > 1500) || (m_flen == CMAX);
          m_gap     = 1;
          ended     = 1;
          m_mode    = MGap;
        end else if (isc) begin
          m_ctrl_err = 1;
          m_mode     = MWait;
          break;
        end else begin
          m_len++;
        end
      end else begin
        if (isc && ch == 8'hFB && k == 0) begin
          if (m_mode == MGap) m_ipg_err = (m_gap < 12) || (m_gap > 40);
          m_mode  = MFrame;
          m_len   = 0;
          started = 1;
        end else begin
          if (!isc || ch != 8'h07) m_ctrl_err = 1;
          if (m_mode == MGap) m_gap++;
        end
      end
    end
  endtask

  task automatic step(input beat_t b, input bit clr);
    valid = b.v;
    data  = b.d;
    ctrl  = b.c;
    clear = clr;
    model_beat(b, clr);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
  endtask

  function automatic beat_t idle_b();
    beat_t b;
    b.v = 1; b.d = {8{8'h07}}; b.c = 8'hFF;
    return b;
  endfunction

  function automatic beat_t start_b();
    beat_t b;
    b.v = 1; b.d = {$urandom, $urandom}; b.d[7:0] = 8'hFB; b.c = 8'h01;
    return b;
  endfunction

  function automatic beat_t data_b();
    beat_t b;
    b.v = 1; b.d = {$urandom, $urandom}; b.c = 8'h00;
    return b;
  endfunction

  function automatic beat_t term_b(input int t);
    beat_t b;
    b.v = 1; b.d = {$urandom, $urandom}; b.c = 8'hFF << t;
    for (int k = t; k < NL; k++) b.d[8*k +: 8] = (k == t) ? 8'hFD : 8'h07;
    return b;
  endfunction

  function automatic beat_t invalid_b();
    beat_t b;
    b.v = 0; b.d = {$urandom, $urandom}; b.c = 8'($urandom);
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; data = '0; ctrl = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, len_err, ipg_err, ctrl_err, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b required 00000", {done, len_err, ipg_err, ctrl_err, busy});
    end
    n_checks++;
    if (flen !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame_len: got %0d required 0", flen);
    end
    n_checks++;
    if ({fcnt, ecnt} !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d required 0/0", fcnt, ecnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    step(start_b(), 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b required 1", busy); end
    repeat (7) step(data_b(), 0);
    step(term_b(1), 0);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL good_done: got %b required 1", done); end
    n_checks++;
    if (flen !== 16'd64) begin n_fail++; $display("FAIL good_len: got %0d required 64", flen); end
    n_checks++;
    if ({len_err, ipg_err, ctrl_err} !== 3'b0) begin
      n_fail++; $display("FAIL good_errors: got %b required 000", {len_err, ipg_err, ctrl_err});
    end
    step(idle_b(), 0);
    n_checks++;
    if (fcnt !== 16'd1) begin n_fail++; $display("FAIL good_count: got %0d required 1", fcnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL good_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_ipg_ok();
    step(start_b(), 0);
    n_checks++;
    if (ipg_err !== 1'b0) begin n_fail++; $display("FAIL ipg15: got %b required 0", ipg_err); end
    repeat (6) step(data_b(), 0);
    step(term_b(7), 0);
    n_checks++;
    if (flen !== 16'd62 || done !== 1'b1) begin
      n_fail++; $display("FAIL ipg_frame_len: got %0d done %b required 62 done 1", flen, done);
    end
  endtask

  task automatic test_ipg_err();
    step(idle_b(), 0);
    step(start_b(), 0);
    n_checks++;
    if (ipg_err !== 1'b1) begin n_fail++; $display("FAIL ipg9: got %b required 1", ipg_err); end
    step(data_b(), 0);
    n_checks++;
    if (ecnt !== 16'd1) begin n_fail++; $display("FAIL ipg_err_count: got %0d required 1", ecnt); end
    repeat (5) step(data_b(), 0);
    step(term_b(3), 0);
    n_checks++;
    if (flen !== 16'd58 || len_err !== 1'b0) begin
      n_fail++; $display("FAIL ipg_err_frame: got %0d lerr %b required 58 lerr 0", flen, len_err);
    end
  endtask

  task automatic test_short_frame();
    step(idle_b(), 0);
    step(start_b(), 0);
    n_checks++;
    if (ipg_err !== 1'b0) begin n_fail++; $display("FAIL short_ipg13: got %b required 0", ipg_err); end
    repeat (2) step(data_b(), 0);
    step(term_b(0), 0);
    n_checks++;
    if ({done, len_err} !== 2'b11) begin
      n_fail++; $display("FAIL short_flags: got %b required 11", {done, len_err});
    end
    n_checks++;
    if (flen !== 16'd23) begin n_fail++; $display("FAIL short_len: got %0d required 23", flen); end
    step(idle_b(), 0);
    n_checks++;
    if (ecnt !== 16'd2) begin n_fail++; $display("FAIL short_err_count: got %0d required 2", ecnt); end
  endtask

  task automatic test_ctrl_abort();
    step(start_b(), 0);
    repeat (5) step(data_b(), 0);
    step(term_b(7), 0);
    step(start_b(), 0);
    n_checks++;
    if (ipg_err !== 1'b1) begin n_fail++; $display("FAIL abort_gap1: got %b required 1", ipg_err); end
    begin
      beat_t b;
      b = data_b();
      b.d[31:24] = 8'h9C;
      b.c[3] = 1'b1;
      step(b, 0);
    end
    n_checks++;
    if ({ctrl_err, done, busy} !== 3'b100) begin
      n_fail++; $display("FAIL abort_flags: got %b required 100", {ctrl_err, done, busy});
    end
    step(start_b(), 0);
    n_checks++;
    if ({ipg_err, busy} !== 2'b01) begin
      n_fail++; $display("FAIL abort_restart: got %b required 01", {ipg_err, busy});
    end
    repeat (6) step(data_b(), 0);
    step(term_b(2), 0);
    n_checks++;
    if (flen !== 16'd57) begin n_fail++; $display("FAIL abort_next_len: got %0d required 57", flen); end
  endtask

  task automatic test_clear_on_done();
    repeat (2) step(idle_b(), 0);
    step(start_b(), 0);
    repeat (6) step(data_b(), 0);
    step(term_b(0), 0);
    step(idle_b(), 1);
    n_checks++;
    if ({fcnt, ecnt} !== 32'd0) begin
      n_fail++; $display("FAIL clear_win: got %0d/%0d required 0/0", fcnt, ecnt);
    end
  endtask

  task automatic test_reset_midframe();
    step(idle_b(), 0);
    step(start_b(), 0);
    step(data_b(), 0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, fcnt} !== 17'd0) begin
      n_fail++; $display("FAIL async_reset: got busy %b count %0d required 0/0", busy, fcnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(start_b(), 0);
    n_checks++;
    if ({ipg_err, ctrl_err, done} !== 3'b0) begin
      n_fail++; $display("FAIL reset_restart: got %b required 000", {ipg_err, ctrl_err, done});
    end
    repeat (6) step(data_b(), 0);
    step(term_b(4), 0);
    n_checks++;
    if (flen !== 16'd59 || done !== 1'b1) begin
      n_fail++; $display("FAIL reset_next_frame: got %0d done %b required 59 done 1", flen, done);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    byte unsigned codes[5];
    bit clr;
    for (int f = 0; f < 40; f++) begin
      q.delete();
      repeat ($urandom_range(0, 3)) q.push_back(idle_b());
      q.push_back(start_b());
      repeat ($urandom_range(3, 12)) q.push_back(data_b());
      q.push_back(term_b($urandom_range(0, 7)));
      foreach (q[i]) begin
        if ($urandom_range(0, 5) == 0) q.insert(i, invalid_b());
      end
      foreach (q[i]) begin
        b = q[i];
        if (b.v && $urandom_range(0, 19) == 0) begin
          int l;
          codes = '{8'h07, 8'hFB, 8'hFD, 8'h9C, 8'h00};
          codes[4] = 8'($urandom);
          l = $urandom_range(0, 7);
          b.c[l] = 1'b1;
          b.d[8*l +: 8] = codes[$urandom_range(0, 4)];
        end
        clr = ($urandom_range(0, 19) == 0);
        step(b, clr);
        n_checks++;
        if ({done, len_err, ipg_err, ctrl_err} !== {m_done, m_len_err, m_ipg_err, m_ctrl_err}) begin
          n_fail++;
          $display("FAIL rand_pulses f%0d: got %b required %b", f,
                   {done, len_err, ipg_err, ctrl_err}, {m_done, m_len_err, m_ipg_err, m_ctrl_err});
        end
        n_checks++;
        if (flen !== 16'(m_flen)) begin
          n_fail++; $display("FAIL rand_len f%0d: got %0d required %0d", f, flen, m_flen);
        end
        n_checks++;
        if (busy !== (m_mode == MFrame)) begin
          n_fail++; $display("FAIL rand_busy f%0d: got %b required %b", f, busy, m_mode == MFrame);
        end
        n_checks++;
        if (fcnt !== 16'(m_fc) || ecnt !== 16'(m_ec)) begin
          n_fail++;
          $display("FAIL rand_counts f%0d: got %0d/%0d required %0d/%0d", f, fcnt, ecnt, m_fc, m_ec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_ipg_ok();
    test_ipg_err();
    test_short_frame();
    test_ctrl_abort();
    test_clear_on_done();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
